// File: rtl/fifo_if.sv
// ---------------------------------------------------------------------------
// fifo_if
//
// Purpose:
//   Groups the request/status signals of the single-clock block FIFO so that
//   producers/consumers and the FIFO itself share one bundle. Clock and reset
//   are deliberately kept out of the bundle and stay plain module ports.
//
// Signals:
//   fifo_write_e  write request for the current cycle
//   fifo_wdata    write data, sampled together with fifo_write_e
//   fifo_read_e   read request for the current cycle
//   fifo_rdata    registered read data, holds the last word read
//   fifo_full     occupancy equals capacity
//   fifo_empty    occupancy is zero
//   fifo_ready    FIFO accepts requests in this cycle
//
// Modports:
//   master  the user side (drives requests, observes status and data)
//   slave   the FIFO side (observes requests, drives status and data)
// ---------------------------------------------------------------------------
interface fifo_if #(
    parameter int DATA_WIDTH = 128
);

    logic                  fifo_write_e;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic                  fifo_read_e;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_ready;

    modport master (
        output fifo_write_e,
        output fifo_wdata,
        output fifo_read_e,
        input  fifo_rdata,
        input  fifo_full,
        input  fifo_empty,
        input  fifo_ready
    );

    modport slave (
        input  fifo_write_e,
        input  fifo_wdata,
        input  fifo_read_e,
        output fifo_rdata,
        output fifo_full,
        output fifo_empty,
        output fifo_ready
    );

endinterface

// File: rtl/fifo.sv
// ---------------------------------------------------------------------------
// fifo
//
// Purpose:
//   Synchronous single-clock FIFO of DEPTH words of DATA_WIDTH bits, used to
//   buffer 128-bit AES blocks between stream producers and consumers.
//   The read port is registered: an accepted read loads the head word into
//   fifo_rdata on the clock edge (no first-word fall-through).
//   A cycle in which both a read and a write are accepted is followed by
//   exactly one cycle with fifo_ready low, during which all requests are
//   ignored.
//
// Parameters:
//   ADDR_WIDTH  width of pointers and occupancy counter
//               (2**ADDR_WIDTH must be >= DEPTH+1)
//   DATA_WIDTH  word width in bits
//   DEPTH       capacity in words, any value >= 2
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (0 clears all state immediately)
//   bus    fifo_if.slave bundle (write/read requests, data, status flags)
//
// Optional feature (macro FIFO_SIM_CHECKS_EN):
//   When defined, simulation-only checks flag writes while full, reads while
//   empty, and any request while fifo_ready is low. Datapath behaviour is the
//   same with or without the macro; leave it undefined for synthesis.
// ---------------------------------------------------------------------------
module fifo #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 11
) (
    input  logic  clk,
    input  logic  reset,
    fifo_if.slave bus
);

    // Memory is indexed with only the low pointer bits that can address DEPTH
    // entries; the full-width pointers never exceed DEPTH-1.
    localparam int                    IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] FULL_COUNT = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_stall;

    logic                  w_ready;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [ADDR_WIDTH-1:0] w_wr_ptr_next;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_next;
    logic [ADDR_WIDTH-1:0] w_count_next;

    // The only reason to refuse requests is the recovery cycle that follows a
    // simultaneous read+write; full and empty do not affect ready.
    assign w_ready = ~r_stall;

    // A write into a full FIFO is refused even if a read is accepted in the
    // same cycle; the producer must retry. A read of an empty FIFO is refused
    // even if a write lands in the same cycle, so that word is not returned.
    assign w_wr_accept = bus.fifo_write_e & w_ready & ~r_full;
    assign w_rd_accept = bus.fifo_read_e  & w_ready & ~r_empty;

    // Pointers wrap explicitly at DEPTH-1 because DEPTH need not be a power
    // of two.
    assign w_wr_ptr_next = (r_wr_ptr == LAST_IDX) ? '0 : (r_wr_ptr + ONE);
    assign w_rd_ptr_next = (r_rd_ptr == LAST_IDX) ? '0 : (r_rd_ptr + ONE);

    // Occupancy moves only when exactly one side is accepted.
    always_comb begin
        w_count_next = r_count;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_next = r_count + ONE;
            2'b01:   w_count_next = r_count - ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage array has no reset: stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr[IDX_WIDTH-1:0]] <= bus.fifo_wdata;
        end
    end

    // Pointer, occupancy and flag state. Flags are registered from the next
    // occupancy so they line up with the count after every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

    // Registered read port: the head word is captured on the accepting edge
    // and then held until the next accepted read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (w_rd_accept) begin
            r_rdata <= r_mem[r_rd_ptr[IDX_WIDTH-1:0]];
        end
    end

    // One-cycle stall after a simultaneous accepted read and write. While
    // stalled nothing can be accepted, so the stall always clears on the
    // following edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= 1'b0;
        end else begin
            r_stall <= w_wr_accept & w_rd_accept;
        end
    end

    assign bus.fifo_rdata = r_rdata;
    assign bus.fifo_full  = r_full;
    assign bus.fifo_empty = r_empty;
    assign bus.fifo_ready = w_ready;

`ifdef FIFO_SIM_CHECKS_EN
    // Simulation-only protocol monitor: flags requests that the FIFO will
    // silently drop. It observes only and never changes datapath behaviour.
    always @(posedge clk) begin
        if (reset) begin
            if (bus.fifo_write_e && r_full) begin
                $error("fifo: write requested while full");
            end
            if (bus.fifo_read_e && r_empty) begin
                $error("fifo: read requested while empty");
            end
            if ((bus.fifo_write_e || bus.fifo_read_e) && !w_ready) begin
                $error("fifo: request while not ready");
            end
        end
    end
`else
    // Without the monitor, refused requests are dropped silently.
`endif

endmodule

// File: tb/tb_fifo.sv
// ---------------------------------------------------------------------------
// tb_fifo
//
// Purpose:
//   Self-checking bench for fifo. Random data words and random request
//   patterns are driven; expected outputs come from a queue-based model of
//   the FIFO rules (accept conditions, one-cycle stall after a simultaneous
//   read+write, registered read data).
// ---------------------------------------------------------------------------
module tb_fifo;

    localparam int DW    = 128;
    localparam int AW    = 9;
    localparam int DEPTH = 11;

    logic clk  = 1'b0;
    logic rstN = 1'b1;

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    fifo_if #(.DATA_WIDTH(DW)) bus ();

    fifo #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(rstN),
        .bus  (bus.slave)
    );

    // Reference model state
    logic [DW-1:0] modelQ[$];
    logic [DW-1:0] modelRdata;
    bit            modelReady;

    int checkCount = 0;
    int failCount  = 0;

    function automatic logic [DW-1:0] randWord();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic modelReset();
        modelQ.delete();
        modelRdata = '0;
        modelReady = 1'b1;
    endtask

    // Drive one cycle of requests, advance the model across the rising edge,
    // then return 1 time unit after the edge so outputs can be sampled.
    task automatic applyStimulus(input bit we, input logic [DW-1:0] wd, input bit re);
        bit wrAcc;
        bit rdAcc;
        bus.fifo_write_e = we;
        bus.fifo_wdata   = wd;
        bus.fifo_read_e  = re;
        @(posedge clk);
        if (!rstN) begin
            modelReset();
        end else begin
            wrAcc = we && modelReady && (modelQ.size() < DEPTH);
            rdAcc = re && modelReady && (modelQ.size() > 0);
            if (rdAcc) modelRdata = modelQ.pop_front();
            if (wrAcc) modelQ.push_back(wd);
            modelReady = !(wrAcc && rdAcc);
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic expFull;
        logic expEmpty;
        logic expReady;
        expFull  = (modelQ.size() == DEPTH);
        expEmpty = (modelQ.size() == 0);
        expReady = modelReady;

        checkCount++;
        assert (bus.fifo_rdata === modelRdata) else begin
            failCount++;
            $error("[TB] FAIL %s rdata: got %h expected %h", tag, bus.fifo_rdata, modelRdata);
        end
        checkCount++;
        assert (bus.fifo_full === expFull) else begin
            failCount++;
            $error("[TB] FAIL %s full: got %b expected %b", tag, bus.fifo_full, expFull);
        end
        checkCount++;
        assert (bus.fifo_empty === expEmpty) else begin
            failCount++;
            $error("[TB] FAIL %s empty: got %b expected %b", tag, bus.fifo_empty, expEmpty);
        end
        checkCount++;
        assert (bus.fifo_ready === expReady) else begin
            failCount++;
            $error("[TB] FAIL %s ready: got %b expected %b", tag, bus.fifo_ready, expReady);
        end
    endtask

    task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input string tag);
        applyStimulus(we, wd, re);
        checkOutput(tag);
    endtask

    // Directed sequence with random data and random request mixes
    initial begin
        bus.fifo_write_e = 1'b0;
        bus.fifo_wdata   = '0;
        bus.fifo_read_e  = 1'b0;
        modelReset();

        // Reset asserted, then released
        #2 rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkOutput("inReset");
        rstN = 1'b1;
        step(1'b0, '0, 1'b0, "afterReset");

        // Fill to capacity, then a refused 12th write
        for (int i = 0; i < DEPTH; i++) step(1'b1, randWord(), 1'b0, "fill");
        step(1'b1, randWord(), 1'b0, "writeWhenFull");

        // Alternate read-one / write-one from full, wrapping both pointers
        for (int i = 0; i < 50; i++) begin
            if (i % 2 == 0) step(1'b0, '0, 1'b1, "altRead");
            else            step(1'b1, randWord(), 1'b0, "altWrite");
        end

        // Read+write while full: only the read is accepted, no stall
        step(1'b1, randWord(), 1'b1, "rwWhenFull");
        step(1'b1, randWord(), 1'b0, "refill");

        // Drain with read held high, then an extra read of an empty FIFO
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain");
        step(1'b0, '0, 1'b1, "readWhenEmpty");

        // Read+write on an empty FIFO: only the write lands
        step(1'b1, randWord(), 1'b1, "rwWhenEmpty");
        step(1'b0, '0, 1'b1, "drainOne");

        // Simultaneous read+write pairs separated by the stall cycle; random
        // requests during the stall cycle must be ignored
        step(1'b1, randWord(), 1'b0, "preload");
        for (int i = 0; i < 50; i++) begin
            step(1'b1, randWord(), 1'b1, "simultaneous");
            step(($urandom_range(0, 1) == 1), randWord(), ($urandom_range(0, 1) == 1), "stallCycle");
        end
        step(1'b0, '0, 1'b1, "finalRead");
        step(1'b0, '0, 1'b0, "idleAfterFinal");

        // Random request mix
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) < 55), randWord(), ($urandom_range(0, 99) < 45), "random");
        end

        // Empty out, store 5 words, then reset mid-cycle
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            if (modelQ.size() > 0 || !modelReady) step(1'b0, '0, 1'b1, "preResetDrain");
        end
        for (int i = 0; i < 5; i++) step(1'b1, randWord(), 1'b0, "preResetFill");
        #2 rstN = 1'b0;
        modelReset();
        #1 checkOutput("midReset");
        step(1'b0, '0, 1'b1, "readInReset");
        rstN = 1'b1;
        step(1'b0, '0, 1'b1, "readAfterReset");
        step(1'b0, '0, 1'b1, "readAfterReset2");

        // Normal operation resumes after reset
        step(1'b1, randWord(), 1'b0, "postResetWrite");
        step(1'b0, '0, 1'b1, "postResetRead");

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
